// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_pkg
//  Brief    : Axis timing descriptor, total-length helper and standard modes
//  Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  // One raster axis: visible span, front porch, sync pulse, back porch, pulse level
  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
    logic        pol;
  } axis_cfg_t;

  localparam int unsigned AXIS_H = 0;
  localparam int unsigned AXIS_V = 1;

  // Full period of an axis in pixels (H) or lines (V)
  function automatic int unsigned axis_total(input axis_cfg_t cfg);
    return cfg.active + cfg.fp + cfg.sync + cfg.bp;
  endfunction

  // Standard modes, indexed by AXIS_H / AXIS_V
  localparam axis_cfg_t [1:0] VGA_640x480 = '{
    '{active: 480, fp: 10, sync: 2,   bp: 33, pol: 1'b0},
    '{active: 640, fp: 16, sync: 96,  bp: 48, pol: 1'b0}
  };
  localparam axis_cfg_t [1:0] SVGA_800x600 = '{
    '{active: 600, fp: 1,  sync: 4,   bp: 23, pol: 1'b1},
    '{active: 800, fp: 40, sync: 128, bp: 88, pol: 1'b1}
  };

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen_if
//  Brief    : Run control and raster outputs of the VGA timing generator
//  Revision : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if #(
  parameter int unsigned H_BITS = 10,
  parameter int unsigned V_BITS = 10
);
  logic              en;
  logic              pix_tick;
  logic              h_sync;
  logic              v_sync;
  logic              disp_ena;
  logic              n_blank;
  logic              n_sync;
  logic [H_BITS-1:0] col;
  logic [V_BITS-1:0] row;
  logic              line_start;
  logic              frame_start;

  // Generator side
  modport master (
    input  en,
    output pix_tick, h_sync, v_sync, disp_ena, n_blank, n_sync,
    output col, row, line_start, frame_start
  );

  // Pixel pipeline / controller side
  modport slave (
    output en,
    input  pix_tick, h_sync, v_sync, disp_ena, n_blank, n_sync,
    input  col, row, line_start, frame_start
  );
endinterface
`default_nettype wire

// File: rtl/vga_axis_timer.sv
`default_nettype none
// ============================================================================
//  Module   : vga_axis_timer
//  Brief    : One raster axis: wrapping position counter, wrap flag and
//             active/pulse decode of the position it will hold next edge
//  Revision : 1.0 - initial release
// ============================================================================
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter axis_cfg_t   CFG  = VGA_640x480[AXIS_H],
  parameter int unsigned BITS = $clog2(axis_total(CFG))
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            adv,
  output logic      [BITS-1:0] cnt_nxt,
  output logic                 wrap,
  output logic                 active_nxt,
  output logic                 pulse_nxt
);

  localparam int unsigned     TOTAL       = axis_total(CFG);
  localparam logic [BITS-1:0] C_LAST      = BITS'(TOTAL - 1);
  localparam logic [BITS-1:0] C_ACT_END   = BITS'(CFG.active);
  localparam logic [BITS-1:0] C_PULSE_BEG = BITS'(CFG.active + CFG.fp);
  localparam logic [BITS-1:0] C_PULSE_END = BITS'(CFG.active + CFG.fp + CFG.sync);

  logic [BITS-1:0] cnt_q;
  logic [BITS-1:0] cnt_d;

  // Next position and its decode; outputs are looked at before the edge so
  // the top can register them in step with the counter
  always_comb begin
    wrap  = (cnt_q == C_LAST);
    cnt_d = cnt_q;
    if (adv) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
    cnt_nxt    = cnt_d;
    active_nxt = (cnt_d < C_ACT_END);
    pulse_nxt  = (cnt_d >= C_PULSE_BEG) && (cnt_d < C_PULSE_END);
  end

  // Position register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Brief    : VGA raster timing generator: pixel prescaler, H/V axis timers,
//             registered sync/blank/position outputs and line/frame strobes
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CLK_DIV  = 1
) (
  input wire logic          clk,
  input wire logic          rst,
  vga_timing_gen_if.master  bus
);

  localparam axis_cfg_t   H_CFG    = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP, pol: H_POL};
  localparam axis_cfg_t   V_CFG    = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP, pol: V_POL};
  localparam int unsigned H_BITS   = $clog2(axis_total(H_CFG));
  localparam int unsigned V_BITS   = $clog2(axis_total(V_CFG));
  localparam int unsigned DIV_BITS = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_BITS-1:0] C_DIV_LAST = DIV_BITS'(CLK_DIV - 1);

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 || CLK_DIV < 1) begin : g_bad_cfg
    $error("vga_timing_gen: active/porch/pulse terms must be nonzero and CLK_DIV >= 1");
  end

  logic [DIV_BITS-1:0] div_q, div_d;
  logic                tick;
  logic [H_BITS-1:0]   h_cnt_nxt;
  logic [V_BITS-1:0]   v_cnt_nxt;
  logic                h_wrap, v_wrap;
  logic                h_act_nxt, v_act_nxt;
  logic                h_pulse_nxt, v_pulse_nxt;

  logic              pix_tick_q, pix_tick_d;
  logic              h_sync_q, h_sync_d;
  logic              v_sync_q, v_sync_d;
  logic              disp_ena_q, disp_ena_d;
  logic              n_blank_q, n_blank_d;
  logic              n_sync_q, n_sync_d;
  logic [H_BITS-1:0] col_q, col_d;
  logic [V_BITS-1:0] row_q, row_d;
  logic              line_start_q, line_start_d;
  logic              frame_start_q, frame_start_d;

  vga_axis_timer #(.CFG(H_CFG), .BITS(H_BITS)) u_h_axis (
    .clk        (clk),
    .rst        (rst),
    .adv        (tick),
    .cnt_nxt    (h_cnt_nxt),
    .wrap       (h_wrap),
    .active_nxt (h_act_nxt),
    .pulse_nxt  (h_pulse_nxt)
  );

  // Lines advance only on the tick that wraps the horizontal counter
  vga_axis_timer #(.CFG(V_CFG), .BITS(V_BITS)) u_v_axis (
    .clk        (clk),
    .rst        (rst),
    .adv        (tick & h_wrap),
    .cnt_nxt    (v_cnt_nxt),
    .wrap       (v_wrap),
    .active_nxt (v_act_nxt),
    .pulse_nxt  (v_pulse_nxt)
  );

  // Prescaler and output decode; non-strobe outputs only move on a tick so
  // they stay aligned with the counters they describe
  always_comb begin
    div_d = div_q;
    tick  = 1'b0;
    if (bus.en) begin
      if (div_q == C_DIV_LAST) begin
        div_d = '0;
        tick  = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    pix_tick_d    = tick;
    line_start_d  = tick & h_wrap;
    frame_start_d = tick & h_wrap & v_wrap;

    h_sync_d   = h_sync_q;
    v_sync_d   = v_sync_q;
    disp_ena_d = disp_ena_q;
    n_blank_d  = n_blank_q;
    n_sync_d   = n_sync_q;
    col_d      = col_q;
    row_d      = row_q;
    if (tick) begin
      h_sync_d   = h_pulse_nxt ? H_POL : ~H_POL;
      v_sync_d   = v_pulse_nxt ? V_POL : ~V_POL;
      disp_ena_d = h_act_nxt & v_act_nxt;
      n_blank_d  = h_act_nxt & v_act_nxt;
      n_sync_d   = ~(h_pulse_nxt | v_pulse_nxt);
      if (h_act_nxt) col_d = h_cnt_nxt;
      if (v_act_nxt) row_d = v_cnt_nxt;
    end
  end

  // Prescaler and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q         <= '0;
      pix_tick_q    <= 1'b0;
      h_sync_q      <= ~H_POL;
      v_sync_q      <= ~V_POL;
      disp_ena_q    <= 1'b0;
      n_blank_q     <= 1'b0;
      n_sync_q      <= 1'b1;
      col_q         <= '0;
      row_q         <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      pix_tick_q    <= pix_tick_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      disp_ena_q    <= disp_ena_d;
      n_blank_q     <= n_blank_d;
      n_sync_q      <= n_sync_d;
      col_q         <= col_d;
      row_q         <= row_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.pix_tick    = pix_tick_q;
  assign bus.h_sync      = h_sync_q;
  assign bus.v_sync      = v_sync_q;
  assign bus.disp_ena    = disp_ena_q;
  assign bus.n_blank     = n_blank_q;
  assign bus.n_sync      = n_sync_q;
  assign bus.col         = col_q;
  assign bus.row         = row_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;

endmodule
`default_nettype wire
